color_overlay_pipe: RTL

Pipelined, parametrised colour-class overlay stage between the per-pixel colour detectors and the VGA output mux. It accepts a pixel plus N class-hit flags, resolves priority, and substitutes a programmable palette colour for the winning class. It also produces a binarized mask for one selectable class, and (optionally) per-frame hit counts per class for the tracking logic. Mode and mask-class changes are frame-synchronous, so a frame never tears.

---
 rtl/color_overlay_pipe_if.sv | 32 +++
 rtl/color_overlay_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/color_overlay_pipe_if.sv
// color_overlay_pipe_if
// Pixel stream bundle between the colour detectors, the overlay stage and
// the VGA output mux.
//   master : the pixel source (drives pixel_in, class_hit, in_valid, frame_start)
//   slave  : the overlay stage (drives vga_pixel, binarized_pixel, class_any,
//            class_idx, out_valid)
interface color_overlay_pipe_if #(
   parameter int NUM_CLASSES = 2,
   parameter int PIXEL_W     = 24,
   parameter int IDX_W       = 3
);
   logic [PIXEL_W-1:0]     pixel_in;
   logic [NUM_CLASSES-1:0] class_hit;
   logic                   in_valid;
   logic                   frame_start;

   logic [PIXEL_W-1:0]     vga_pixel;
   logic                   binarized_pixel;
   logic                   class_any;
   logic [IDX_W-1:0]       class_idx;
   logic                   out_valid;

   modport master (
      output pixel_in, class_hit, in_valid, frame_start,
      input  vga_pixel, binarized_pixel, class_any, class_idx, out_valid
   );

   modport slave (
      input  pixel_in, class_hit, in_valid, frame_start,
      output vga_pixel, binarized_pixel, class_any, class_idx, out_valid
   );
endinterface

// File: rtl/color_overlay_pipe.sv
// color_overlay_pipe
// Colour-class overlay stage. Resolves the priority of per-pixel class hits
// (bit 0 wins), substitutes a programmable palette colour according to the
// frame-synchronous mode, and produces a binarized mask for one selectable
// class. Latency is two cycles from acceptance to out_valid.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   px (slave)          pixel stream in / processed pixel out
//   mode, bin_sel       overlay mode and mask class, captured on frame_start
//   cfg_we/addr/data    palette write port
//   class_count         last completed frame's per-class hit counts
//   counts_valid        one-cycle pulse when class_count updates
//
// Optional feature: define OVERLAY_STATS_EN to build the per-class
// frame hit counters; otherwise class_count and counts_valid are tied to 0.
module color_overlay_pipe #(
   parameter int NUM_CLASSES = 2,
   parameter int PIXEL_W     = 24,
   parameter int CNT_W       = 20,
   parameter int IDX_W       = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   color_overlay_pipe_if.slave          px,
   input  logic [1:0]                   mode,
   input  logic [IDX_W-1:0]             bin_sel,
   input  logic                         cfg_we,
   input  logic [IDX_W-1:0]             cfg_addr,
   input  logic [PIXEL_W-1:0]           cfg_data,
   output logic [NUM_CLASSES*CNT_W-1:0] class_count,
   output logic                         counts_valid
);

   function automatic logic [PIXEL_W-1:0] pal_default(input int k);
      case (k)
         0:       return PIXEL_W'(24'h0000FF);
         1:       return PIXEL_W'(24'h00FF00);
         default: return '1;
      endcase
   endfunction

   logic [PIXEL_W-1:0] palette [NUM_CLASSES];
   logic [1:0]         mode_sh;
   logic [IDX_W-1:0]   bin_sh;

   // acceptance-edge decode
   logic [1:0]         mode_eff;
   logic [IDX_W-1:0]   bin_eff;
   logic [IDX_W-1:0]   idx_c;
   logic               any_c;
   logic               bin_c;
   logic [PIXEL_W-1:0] pal_c;

   // stage 1
   logic               s1_valid;
   logic [PIXEL_W-1:0] s1_pix;
   logic [PIXEL_W-1:0] s1_pal;
   logic               s1_any;
   logic [IDX_W-1:0]   s1_idx;
   logic               s1_bin;
   logic [1:0]         s1_mode;

   // stage 2
   logic               s2_valid;
   logic [PIXEL_W-1:0] s2_pix;
   logic               s2_any;
   logic [IDX_W-1:0]   s2_idx;
   logic               s2_bin;
   logic [PIXEL_W-1:0] sel_pix;

   always_comb begin
      // a frame_start pixel already uses the newly captured mode/bin_sel
      mode_eff = px.frame_start ? mode : mode_sh;
      bin_eff  = px.frame_start ? bin_sel : bin_sh;
      any_c    = |px.class_hit;
      idx_c    = '0;
      for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
         if (px.class_hit[k]) idx_c = IDX_W'(k);
      end
      // out-of-range bin_sel matches no class and yields 0
      bin_c = 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
         if (bin_eff == IDX_W'(k)) bin_c = px.class_hit[k];
      end
      // palette colour is frozen at acceptance; a write on the same edge
      // is forwarded so the accepted pixel sees the new colour
      pal_c = '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
         if (idx_c == IDX_W'(k)) begin
            pal_c = (cfg_we && cfg_addr == IDX_W'(k)) ? cfg_data : palette[k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CLASSES; k++) palette[k] <= pal_default(k);
         mode_sh  <= 2'd1;
         bin_sh   <= '0;
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_pal   <= '0;
         s1_any   <= 1'b0;
         s1_idx   <= '0;
         s1_bin   <= 1'b0;
         s1_mode  <= 2'd1;
      end else begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cfg_we && cfg_addr == IDX_W'(k)) palette[k] <= cfg_data;
         end
         if (px.in_valid && px.frame_start) begin
            mode_sh <= mode;
            bin_sh  <= bin_sel;
         end
         s1_valid <= px.in_valid;
         if (px.in_valid) begin
            s1_pix  <= px.pixel_in;
            s1_pal  <= pal_c;
            s1_any  <= any_c;
            s1_idx  <= idx_c;
            s1_bin  <= bin_c;
            s1_mode <= mode_eff;
         end
      end
   end

   always_comb begin
      case (s1_mode)
         2'd0:    sel_pix = s1_pix;
         2'd1:    sel_pix = s1_any ? s1_pal : s1_pix;
         2'd2:    sel_pix = s1_any ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
         default: sel_pix = s1_any ? s1_pal : {PIXEL_W{1'b0}};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid           <= 1'b0;
         s2_pix             <= '0;
         s2_any             <= 1'b0;
         s2_idx             <= '0;
         s2_bin             <= 1'b0;
         px.out_valid       <= 1'b0;
         px.vga_pixel       <= '0;
         px.class_any       <= 1'b0;
         px.class_idx       <= '0;
         px.binarized_pixel <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_pix <= sel_pix;
            s2_any <= s1_any;
            s2_idx <= s1_idx;
            s2_bin <= s1_bin;
         end
         // outputs hold their last value across gaps
         px.out_valid <= s2_valid;
         if (s2_valid) begin
            px.vga_pixel       <= s2_pix;
            px.class_any       <= s2_any;
            px.class_idx       <= s2_idx;
            px.binarized_pixel <= s2_bin;
         end
      end
   end

`ifdef OVERLAY_STATS_EN
   logic [CNT_W-1:0] ctr [NUM_CLASSES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CLASSES; k++) ctr[k] <= '0;
         class_count  <= '0;
         counts_valid <= 1'b0;
      end else begin
         counts_valid <= 1'b0;
         if (px.in_valid) begin
            if (px.frame_start) begin
               // publish the finished frame; the new frame starts with
               // this pixel's own hits
               counts_valid <= 1'b1;
               for (int k = 0; k < NUM_CLASSES; k++) begin
                  class_count[k*CNT_W +: CNT_W] <= ctr[k];
                  ctr[k] <= {{(CNT_W-1){1'b0}}, px.class_hit[k]};
               end
            end else begin
               for (int k = 0; k < NUM_CLASSES; k++) begin
                  if (px.class_hit[k] && ctr[k] != {CNT_W{1'b1}}) ctr[k] <= ctr[k] + 1'b1;
               end
            end
         end
      end
   end
`else
   assign class_count  = '0;
   assign counts_valid = 1'b0;
`endif

endmodule
